// File: rtl/mem_write_buffer.sv
// mem_write_buffer
//   Store buffer between a CPU data port and a single-ported data memory.
//   Stores are queued in a DEPTH-entry FIFO. They retire to memory in
//   arrival order whenever the memory port is not being used by a load.
//
//   Parameter
//     DEPTH          number of buffered store entries (power of two, 2..16)
//
//   Ports
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset; discards all buffered stores
//     cpu_memread    CPU load request
//     cpu_memwrite   CPU store request
//     cpu_address    CPU word address (shared by load and store)
//     cpu_writedata  CPU store data
//     cpu_readdata   load result (combinational; 0 when no load is serviced)
//     stall          CPU must hold its request and retry next cycle
//     mem_memread    memory read strobe
//     mem_memwrite   memory write strobe (head entry being retired)
//     mem_address    memory address (0 when the port is idle)
//     mem_writedata  memory write data (0 when not retiring)
//     mem_readdata   memory read data
//     empty          no entries held
//
//   Build option
//     WBUF_FORWARD_EN  defined: loads are forwarded from the newest matching
//                      buffered store, or read from memory, without stalling;
//                      draining pauses while a load is requested.
//                      undefined: a load stalls until the buffer has drained.
module mem_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        stall,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic        empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic full;
    logic pop;
    logic push;
    logic read_claim;
    logic read_stall;
    logic write_stall;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Control. The pop decision is made from the raw load request rather than
    // from the claimed read so that stall, pop and claim have no combinational
    // loop: with the buffer full and a load+store pending, the store stalls and
    // the port stays idle until the load request goes away.
    always_comb begin
        pop         = 1'b0;
        read_stall  = 1'b0;
        write_stall = 1'b0;
        stall       = 1'b0;
        read_claim  = 1'b0;
        push        = 1'b0;
        if (rst_n) begin
`ifdef WBUF_FORWARD_EN
            pop        = !empty && !cpu_memread;
            read_stall = 1'b0;
`else
            pop        = !empty;
            read_stall = cpu_memread && !empty;
`endif
            write_stall = cpu_memwrite && full && !pop;
            stall       = read_stall || write_stall;
            read_claim  = cpu_memread && !stall;
            push        = cpu_memwrite && !stall;
        end
    end

    // Memory port: a claimed read wins, otherwise the head entry retires.
    always_comb begin
        mem_memread   = read_claim;
        mem_memwrite  = pop;
        mem_address   = '0;
        mem_writedata = '0;
        if (read_claim) begin
            mem_address = cpu_address;
        end else if (pop) begin
            mem_address   = addr_q[head_q];
            mem_writedata = data_q[head_q];
        end
    end

`ifdef WBUF_FORWARD_EN
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Walk from oldest to newest so the last match is the newest entry.
    // Only registered contents are searched: a store in the same cycle is
    // not visible to the load.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q &&
                addr_q[head_q + PTR_W'(i)] == cpu_address) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PTR_W'(i)];
            end
        end
    end

    always_comb begin
        cpu_readdata = '0;
        if (read_claim) begin
            cpu_readdata = fwd_hit ? fwd_data : mem_readdata;
        end
    end
`else
    always_comb begin
        cpu_readdata = '0;
        if (read_claim) begin
            cpu_readdata = mem_readdata;
        end
    end
`endif

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= cpu_address;
            data_q[tail_q] <= cpu_writedata;
        end
    end

endmodule
